icm_get_proc_thread_2: RTL and testbench
========================================

Name: icm_get_proc_thread_2

Overview:
- Second stage of the ICMGet processing pipeline. Consumes buffered ICMGet request heads from the ReqFIFO written by the request-buffering stage.
- Decodes each head's ICM address into cache set/tag/offset and issues one tag lookup to the ICM cache array.
- Hits go to the response path with the cached entry. Misses go to the miss (DMA fetch) path with the full original head.

Parameters:
- COUNT_MAX_LOG, 2, width of each count field in the head
- MAX_REQ_TAG_NUM_LOG, 5, width of the request tag field
- PHYSICAL_ADDR_WIDTH, 64, width of the physical address field
- ICM_ADDR_WIDTH, 64, width of the ICM virtual address field
- HEAD_WIDTH, COUNT_MAX_LOG*2+MAX_REQ_TAG_NUM_LOG+PHYSICAL_ADDR_WIDTH+ICM_ADDR_WIDTH, total head width
- CACHE_OFFSET_WIDTH, 5, byte offset bits (32-byte slot)
- CACHE_SET_NUM_LOG, 10, set index bits (1024 sets)
- CACHE_ADDR_WIDTH, 20, significant low bits of the ICM address
- CACHE_TAG_WIDTH, CACHE_ADDR_WIDTH-CACHE_OFFSET_WIDTH-CACHE_SET_NUM_LOG, tag bits (5)
- CACHE_ENTRY_WIDTH, 256, cache entry data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_fifo_empty  in  1  ReqFIFO empty (FWFT)
- req_fifo_dout  in  HEAD_WIDTH  head at FIFO output; valid while !empty
- req_fifo_rd_en  out  1  pop strobe
- lookup_req_valid  out  1  tag lookup request
- lookup_req_set  out  CACHE_SET_NUM_LOG  set index
- lookup_req_tag  out  CACHE_TAG_WIDTH  tag
- lookup_req_ready  in  1  cache accepts lookup
- lookup_rsp_valid  in  1  lookup result strobe (1 cycle)
- lookup_rsp_hit  in  1  hit flag
- lookup_rsp_data  in  CACHE_ENTRY_WIDTH  entry data (valid on hit)
- hit_rsp_valid  out  1  hit response valid
- hit_rsp_head  out  HEAD_WIDTH  original head
- hit_rsp_data  out  CACHE_ENTRY_WIDTH  cached entry
- hit_rsp_ready  in  1  downstream accepts hit
- miss_req_valid  out  1  miss request valid
- miss_req_head  out  HEAD_WIDTH  original head
- miss_req_ready  in  1  miss path accepts

Behaviour:
- Head layout, MSB to LSB: {count_total, count_index, req_tag, phy_addr, icm_addr}.
- Address decode from the latched icm_addr:
  - offset = icm_addr[CACHE_OFFSET_WIDTH-1:0]
  - set = next CACHE_SET_NUM_LOG bits
  - tag = icm_addr[CACHE_ADDR_WIDTH-1 : CACHE_OFFSET_WIDTH+CACHE_SET_NUM_LOG]
  - Bits at and above CACHE_ADDR_WIDTH are ignored.
- Reset (asynchronous, active-high):
  - state=IDLE; every output 0.
  - Latched head/data registers 0.
  - Reset mid-operation discards any in-flight request without emitting it.
- FSM states IDLE, LOOKUP, WAIT_RSP, HIT_OUT, MISS_OUT. One request in flight at a time.
- IDLE: if !req_fifo_empty, latch req_fifo_dout, pulse req_fifo_rd_en for exactly 1 cycle, go to LOOKUP. Never pop in any other state.
- LOOKUP:
  - lookup_req_valid=1, set/tag driven from registers.
  - On valid&&ready, go to WAIT_RSP next cycle.
  - Outputs are held stable while ready=0.
- WAIT_RSP:
  - On lookup_rsp_valid: latch hit flag and data; go to HIT_OUT if hit, else MISS_OUT.
  - A response arriving in the same cycle as LOOKUP acceptance is not legal; the cache guarantees ≥1 cycle latency.
- HIT_OUT: hit_rsp_valid=1 with head/data held stable. On hit_rsp_ready, go to IDLE.
- MISS_OUT: miss_req_valid=1 with head held stable. On miss_req_ready, go to IDLE.
- hit_rsp_valid and miss_req_valid are never asserted together.
- Payload outputs are 0 whenever the matching valid is 0.
- Minimum latency: pop to hit/miss valid = 3 cycles with zero-wait handshakes.
- Minimum per-request occupancy = 4 cycles. The FIFO may be popped again in the cycle after the output handshake.
- Back-pressure on any output stalls the FSM. No FIFO pop occurs while stalled, so the upstream prog_full propagates naturally.

Test Plan:
- Reset with FIFO non-empty, release -> req_fifo_rd_en stays 0 until first IDLE cycle after release; all outputs 0 during reset.
- Head with icm_addr=0x0000_0000_0001_2345, lookup_req_ready=1 -> lookup_req_set=0x11A, lookup_req_tag=0x02, one pop.
- Lookup hit, data=0xA5 repeated, hit_rsp_ready=1 -> hit_rsp_valid 1 cycle, hit_rsp_head equals popped head, hit_rsp_data=0xA5.., miss_req_valid never 1.
- Lookup miss with req_tag=7, miss_req_ready low 5 cycles -> miss_req_valid held 6 cycles with stable head (tag 7), no second pop during stall.
- Three back-to-back heads, all hits, all readies high -> three lookups in order, 4-cycle spacing between pops, responses in FIFO order.
- lookup_req_ready low 3 cycles, then assert rst mid-LOOKUP -> all valids drop immediately, state IDLE, no response emitted for that head.

Source files
------------

// File: rtl/icm_get_proc_thread_2.sv
// icm_get_proc_thread_2
// Second stage of the ICMGet pipeline. It pops one buffered request head from
// the ReqFIFO, decodes the ICM address into a cache set/tag, and issues a single
// tag lookup. A hit is forwarded with the cached entry on the response path. A
// miss is forwarded with the original head on the DMA-fetch path. Only one
// request is in flight at a time.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_fifo_empty/dout/rd_en FWFT ReqFIFO read side (head valid while !empty)
//   lookup_req_*              tag lookup request (valid/ready, set, tag)
//   lookup_rsp_*              lookup result (1-cycle strobe, hit flag, entry)
//   hit_rsp_*                 hit response (valid/ready, head, entry data)
//   miss_req_*                miss request (valid/ready, head)
module icm_get_proc_thread_2 #(
  parameter int COUNT_MAX_LOG       = 2,
  parameter int MAX_REQ_TAG_NUM_LOG = 5,
  parameter int PHYSICAL_ADDR_WIDTH = 64,
  parameter int ICM_ADDR_WIDTH      = 64,
  parameter int HEAD_WIDTH          = COUNT_MAX_LOG*2 + MAX_REQ_TAG_NUM_LOG
                                      + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH,
  parameter int CACHE_OFFSET_WIDTH  = 5,
  parameter int CACHE_SET_NUM_LOG   = 10,
  parameter int CACHE_ADDR_WIDTH    = 20,
  parameter int CACHE_TAG_WIDTH     = CACHE_ADDR_WIDTH - CACHE_OFFSET_WIDTH
                                      - CACHE_SET_NUM_LOG,
  parameter int CACHE_ENTRY_WIDTH   = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_fifo_empty,
  input  logic [HEAD_WIDTH-1:0]        req_fifo_dout,
  output logic                         req_fifo_rd_en,
  output logic                         lookup_req_valid,
  output logic [CACHE_SET_NUM_LOG-1:0] lookup_req_set,
  output logic [CACHE_TAG_WIDTH-1:0]   lookup_req_tag,
  input  logic                         lookup_req_ready,
  input  logic                         lookup_rsp_valid,
  input  logic                         lookup_rsp_hit,
  input  logic [CACHE_ENTRY_WIDTH-1:0] lookup_rsp_data,
  output logic                         hit_rsp_valid,
  output logic [HEAD_WIDTH-1:0]        hit_rsp_head,
  output logic [CACHE_ENTRY_WIDTH-1:0] hit_rsp_data,
  input  logic                         hit_rsp_ready,
  output logic                         miss_req_valid,
  output logic [HEAD_WIDTH-1:0]        miss_req_head,
  input  logic                         miss_req_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    WAIT_RSP = 3'd2,
    HIT_OUT  = 3'd3,
    MISS_OUT = 3'd4
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [HEAD_WIDTH-1:0]          head_p0;
  logic [CACHE_ENTRY_WIDTH-1:0]   data_p1;
  logic [CACHE_SET_NUM_LOG-1:0]   dec_set;
  logic [CACHE_TAG_WIDTH-1:0]     dec_tag;
  logic                           pop;

  // icm_addr occupies the LSBs of the head. The byte offset is not needed for
  // the tag lookup, and address bits above CACHE_ADDR_WIDTH are ignored.
  assign dec_set = head_p0[CACHE_OFFSET_WIDTH +: CACHE_SET_NUM_LOG];
  assign dec_tag = head_p0[CACHE_OFFSET_WIDTH + CACHE_SET_NUM_LOG +: CACHE_TAG_WIDTH];

  // The pop is gated by rst so that no head leaves the FIFO while reset is held.
  assign pop = (state == IDLE) && !req_fifo_empty && !rst;

  // Stage p0: head latched on pop. Stage p1: entry latched on lookup response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      head_p0 <= '0;
      data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        head_p0 <= req_fifo_dout;
      end
      if ((state == WAIT_RSP) && lookup_rsp_valid) begin
        data_p1 <= lookup_rsp_data;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    req_fifo_rd_en   = 1'b0;
    lookup_req_valid = 1'b0;
    lookup_req_set   = '0;
    lookup_req_tag   = '0;
    hit_rsp_valid    = 1'b0;
    hit_rsp_head     = '0;
    hit_rsp_data     = '0;
    miss_req_valid   = 1'b0;
    miss_req_head    = '0;
    case (state)
      IDLE: begin
        req_fifo_rd_en = pop;
        if (pop) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        lookup_req_valid = 1'b1;
        lookup_req_set   = dec_set;
        lookup_req_tag   = dec_tag;
        if (lookup_req_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (lookup_rsp_valid) begin
          state_nxt = lookup_rsp_hit ? HIT_OUT : MISS_OUT;
        end
      end
      HIT_OUT: begin
        hit_rsp_valid = 1'b1;
        hit_rsp_head  = head_p0;
        hit_rsp_data  = data_p1;
        if (hit_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      MISS_OUT: begin
        miss_req_valid = 1'b1;
        miss_req_head  = head_p0;
        if (miss_req_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icm_get_proc_thread_2.sv
// Directed testbench for icm_get_proc_thread_2: reset behaviour, address
// decode, hit and miss paths, miss back-pressure, back-to-back throughput and
// reset during an outstanding lookup.
module tb_icm_get_proc_thread_2;

  localparam int HW = 137;
  localparam int EW = 256;

  logic          clk;
  logic          rst;
  logic          req_fifo_empty;
  logic [HW-1:0] req_fifo_dout;
  logic          req_fifo_rd_en;
  logic          lookup_req_valid;
  logic [9:0]    lookup_req_set;
  logic [4:0]    lookup_req_tag;
  logic          lookup_req_ready;
  logic          lookup_rsp_valid;
  logic          lookup_rsp_hit;
  logic [EW-1:0] lookup_rsp_data;
  logic          hit_rsp_valid;
  logic [HW-1:0] hit_rsp_head;
  logic [EW-1:0] hit_rsp_data;
  logic          hit_rsp_ready;
  logic          miss_req_valid;
  logic [HW-1:0] miss_req_head;
  logic          miss_req_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  icm_get_proc_thread_2 dut (
    .clk              (clk),
    .rst              (rst),
    .req_fifo_empty   (req_fifo_empty),
    .req_fifo_dout    (req_fifo_dout),
    .req_fifo_rd_en   (req_fifo_rd_en),
    .lookup_req_valid (lookup_req_valid),
    .lookup_req_set   (lookup_req_set),
    .lookup_req_tag   (lookup_req_tag),
    .lookup_req_ready (lookup_req_ready),
    .lookup_rsp_valid (lookup_rsp_valid),
    .lookup_rsp_hit   (lookup_rsp_hit),
    .lookup_rsp_data  (lookup_rsp_data),
    .hit_rsp_valid    (hit_rsp_valid),
    .hit_rsp_head     (hit_rsp_head),
    .hit_rsp_data     (hit_rsp_data),
    .hit_rsp_ready    (hit_rsp_ready),
    .miss_req_valid   (miss_req_valid),
    .miss_req_head    (miss_req_head),
    .miss_req_ready   (miss_req_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [HW-1:0] mk_head(input logic [1:0] ct, input logic [1:0] ci,
                                            input logic [4:0] tg, input logic [63:0] pa,
                                            input logic [63:0] ia);
    return {ct, ci, tg, pa, ia};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [HW-1:0] h1, h2, h6;
  logic [HW-1:0] hds [3];
  logic [EW-1:0] dat [3];
  logic [9:0]    exp_set [3];
  logic [4:0]    exp_tag [3];
  int            pop_cyc;
  int            pops;

  initial begin
    h1 = mk_head(2'd1, 2'd0, 5'd3, 64'hDEAD_BEEF_0000_1000, 64'h0000_0000_0001_2345);
    h2 = mk_head(2'd2, 2'd1, 5'd7, 64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFF8_7FE0);
    hds[0] = mk_head(2'd1, 2'd0, 5'd10, 64'h1111, 64'h0000_0000_0000_0000);
    hds[1] = mk_head(2'd3, 2'd2, 5'd11, 64'h2222, 64'h0000_0000_000F_FFFF);
    hds[2] = mk_head(2'd3, 2'd3, 5'd12, 64'h3333, 64'hABCD_0000_0000_8020);
    h6 = mk_head(2'd0, 2'd0, 5'd31, 64'h4444, 64'h0000_0000_0001_2345);
    dat[0] = {32{8'h11}};
    dat[1] = {32{8'h22}};
    dat[2] = {32{8'h33}};
    exp_set[0] = 10'h000; exp_tag[0] = 5'h00;
    exp_set[1] = 10'h3FF; exp_tag[1] = 5'h1F;
    exp_set[2] = 10'h001; exp_tag[2] = 5'h01;

    rst = 1'b1;
    req_fifo_empty = 1'b0;
    req_fifo_dout = h1;
    lookup_req_ready = 1'b0;
    lookup_rsp_valid = 1'b0;
    lookup_rsp_hit = 1'b0;
    lookup_rsp_data = '0;
    hit_rsp_ready = 1'b0;
    miss_req_ready = 1'b0;

    // Reset held with a non-empty FIFO: nothing popped, all outputs quiet.
    repeat (2) tick();
    #1;
    chk("rst_rd_en", req_fifo_rd_en, 0);
    chk("rst_lkp_valid", lookup_req_valid, 0);
    chk("rst_lkp_set", lookup_req_set, 0);
    chk("rst_hit_valid", hit_rsp_valid, 0);
    chk("rst_hit_head", hit_rsp_head, 0);
    chk("rst_miss_valid", miss_req_valid, 0);
    chk("rst_miss_head", miss_req_head, 0);

    // Release reset; first IDLE cycle pops h1.
    tick();
    rst = 1'b0;
    lookup_req_ready = 1'b1;
    hit_rsp_ready = 1'b1;
    #1;
    chk("pop1_rd_en", req_fifo_rd_en, 1);
    pop_cyc = cyc;

    tick(); // LOOKUP
    req_fifo_empty = 1'b1;
    #1;
    chk("lkp1_rd_en", req_fifo_rd_en, 0);
    chk("lkp1_valid", lookup_req_valid, 1);
    chk("lkp1_set", lookup_req_set, 10'h11A);
    chk("lkp1_tag", lookup_req_tag, 5'h02);

    tick(); // WAIT_RSP
    lookup_rsp_valid = 1'b1;
    lookup_rsp_hit = 1'b1;
    lookup_rsp_data = {32{8'hA5}};
    #1;
    chk("wait1_lkp_valid", lookup_req_valid, 0);
    chk("wait1_hit_valid", hit_rsp_valid, 0);

    tick(); // HIT_OUT
    lookup_rsp_valid = 1'b0;
    lookup_rsp_hit = 1'b0;
    lookup_rsp_data = '0;
    #1;
    chk("hit1_valid", hit_rsp_valid, 1);
    chk("hit1_head", hit_rsp_head, h1);
    chk("hit1_data", hit_rsp_data, {32{8'hA5}});
    chk("hit1_miss_valid", miss_req_valid, 0);
    chk("hit1_latency", cyc - pop_cyc, 3);

    tick(); // IDLE, FIFO empty
    #1;
    chk("idle1_hit_valid", hit_rsp_valid, 0);
    chk("idle1_hit_data", hit_rsp_data, 0);
    chk("idle1_rd_en", req_fifo_rd_en, 0);

    // Miss with back-pressure: h2 popped, h3 waits behind it.
    tick();
    req_fifo_empty = 1'b0;
    req_fifo_dout = h2;
    hit_rsp_ready = 1'b0;
    miss_req_ready = 1'b0;
    #1;
    chk("pop2_rd_en", req_fifo_rd_en, 1);

    tick(); // LOOKUP
    req_fifo_dout = hds[0];
    #1;
    chk("lkp2_set", lookup_req_set, 10'h3FF);
    chk("lkp2_tag", lookup_req_tag, 5'h10);
    chk("lkp2_rd_en", req_fifo_rd_en, 0);

    tick(); // WAIT_RSP
    lookup_rsp_valid = 1'b1;
    lookup_rsp_hit = 1'b0;
    lookup_rsp_data = {32{8'h3C}};
    #1;

    tick(); // MISS_OUT, first cycle
    lookup_rsp_valid = 1'b0;
    lookup_rsp_data = '0;
    #1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      chk("miss2_valid", miss_req_valid, 1);
      chk("miss2_head", miss_req_head, h2);
      chk("miss2_hit_valid", hit_rsp_valid, 0);
      if (req_fifo_rd_en) pops++;
      tick();
      if (i == 4) miss_req_ready = 1'b1;
      #1;
    end
    chk("miss2_stall_pops", pops, 0);
    chk("idle2_miss_valid", miss_req_valid, 0);
    chk("idle2_miss_head", miss_req_head, 0);
    miss_req_ready = 1'b0;
    hit_rsp_ready = 1'b1;

    // Three back-to-back hits with all readies high.
    for (int k = 0; k < 3; k++) begin
      chk("b2b_pop", req_fifo_rd_en, 1);
      if (k > 0) chk("b2b_spacing", cyc - pop_cyc, 4);
      pop_cyc = cyc;
      tick(); // LOOKUP
      if (k < 2) req_fifo_dout = hds[k+1];
      else req_fifo_empty = 1'b1;
      #1;
      chk("b2b_lkp_valid", lookup_req_valid, 1);
      chk("b2b_lkp_set", lookup_req_set, exp_set[k]);
      chk("b2b_lkp_tag", lookup_req_tag, exp_tag[k]);
      tick(); // WAIT_RSP
      lookup_rsp_valid = 1'b1;
      lookup_rsp_hit = 1'b1;
      lookup_rsp_data = dat[k];
      #1;
      tick(); // HIT_OUT
      lookup_rsp_valid = 1'b0;
      lookup_rsp_hit = 1'b0;
      lookup_rsp_data = '0;
      #1;
      chk("b2b_hit_valid", hit_rsp_valid, 1);
      chk("b2b_hit_head", hit_rsp_head, hds[k]);
      chk("b2b_hit_data", hit_rsp_data, dat[k]);
      chk("b2b_miss_valid", miss_req_valid, 0);
      tick(); // IDLE
      #1;
    end
    chk("b2b_end_rd_en", req_fifo_rd_en, 0);
    chk("b2b_end_hit_valid", hit_rsp_valid, 0);

    // Lookup stalled for three cycles, then reset while still in LOOKUP.
    lookup_req_ready = 1'b0;
    req_fifo_empty = 1'b0;
    req_fifo_dout = h6;
    #1;
    chk("pop6_rd_en", req_fifo_rd_en, 1);
    tick();
    req_fifo_empty = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall6_lkp_valid", lookup_req_valid, 1);
      chk("stall6_lkp_set", lookup_req_set, 10'h11A);
      chk("stall6_lkp_tag", lookup_req_tag, 5'h02);
      if (i < 2) begin
        tick();
        #1;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    chk("rst6_lkp_valid", lookup_req_valid, 0);
    chk("rst6_lkp_set", lookup_req_set, 0);
    chk("rst6_hit_valid", hit_rsp_valid, 0);
    chk("rst6_miss_valid", miss_req_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    lookup_req_ready = 1'b1;
    hit_rsp_ready = 1'b1;
    miss_req_ready = 1'b1;
    #1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (hit_rsp_valid || miss_req_valid || lookup_req_valid || req_fifo_rd_en) pops++;
      tick();
      #1;
    end
    chk("post_rst_quiet", pops, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
